i2s_dac_transmitter: RTL

Master-mode I2S serializer on the DAC side of the audio path. It accepts one stereo 16-bit sample pair per frame from the DSP stage through a valid/ready handshake and holds it in a one-deep holding buffer. It generates the bit clock and LR clock from CLOCK_50 and shifts the samples out MSB-first to the codec data pin. If no sample arrives in time, it repeats the previous sample pair and flags an underrun.

---
 rtl/i2s_dac_transmitter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: master-mode I2S serializer for the DAC side.
// Takes one stereo 16-bit pair per frame through a one-deep holding buffer and
// shifts it out MSB-first in 32-BCLK slots. If no pair is waiting at the frame
// boundary, it replays the previous pair and pulses underrun.
module i2s_dac_transmitter #(
   parameter int unsigned BCLK_HALF = 12  // CLOCK_50 cycles per BCLK half period, 2..255
) (
   input  logic        CLOCK_50,
   input  logic        AUD_DACLRCK,   // asynchronous, active-high reset
   input  logic [15:0] sample_l,
   input  logic [15:0] sample_r,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        AUD_BCLK_O,
   output logic        LRCK_OUT,
   output logic        AUD_DACDAT,
   output logic        frame_start,
   output logic        underrun
);

   localparam int unsigned DivW = 8;
   localparam logic [DivW-1:0] DivLast = DivW'(BCLK_HALF - 1);

   // Divider and bit-clock state
   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            bclk_q, bclk_d;

   // Frame position and serial outputs
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic            lrck_q, lrck_d;
   logic            dac_q, dac_d;
   logic            frame_start_q, frame_start_d;
   logic            underrun_q, underrun_d;

   // Holding buffer and the pair currently on the wire
   logic            hold_full_q, hold_full_d;
   logic [15:0]     hold_l_q, hold_l_d;
   logic [15:0]     hold_r_q, hold_r_d;
   logic [15:0]     active_l_q, active_l_d;
   logic [15:0]     active_r_q, active_r_d;

   // Decoded events
   logic            div_tc;
   logic            bclk_fall;
   logic            frame_wrap;
   logic            accept;

   // Serializer helpers
   logic [4:0]      slot;
   logic [4:0]      bit_idx;
   logic [15:0]     word;

   // Event decode shared by all next-state logic
   always_comb begin
      div_tc     = (div_cnt_q == DivLast);
      bclk_fall  = div_tc & bclk_q;
      frame_wrap = bclk_fall & (bit_cnt_q == 6'd63);
      accept     = sample_valid & ~hold_full_q;
   end

   // Divider: wrap at terminal count and toggle BCLK
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      bclk_d    = bclk_q;
      if (div_tc) begin
         div_cnt_d = '0;
         bclk_d    = ~bclk_q;
      end
   end

   // Holding buffer: accept only when empty; a frame load empties it.
   // Load and accept never coincide on a full buffer, so a pair accepted in the
   // wrap cycle always lands in the buffer for the following frame.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      active_l_d  = active_l_q;
      active_r_d  = active_r_q;
      if (frame_wrap && hold_full_q) begin
         active_l_d  = hold_l_q;
         active_r_d  = hold_r_q;
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_l_d    = sample_l;
         hold_r_d    = sample_r;
         hold_full_d = 1'b1;
      end
   end

   // Frame sequencing and serializer: everything advances on BCLK falling cycles
   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      lrck_d        = lrck_q;
      dac_d         = dac_q;
      frame_start_d = frame_wrap;
      underrun_d    = frame_wrap & ~hold_full_q;
      slot          = '0;
      bit_idx       = '0;
      word          = '0;
      if (bclk_fall) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
         lrck_d    = bit_cnt_d[5];
         slot      = bit_cnt_d[4:0];
         // Use the post-load pair so slot 1 of a new frame carries the new MSB
         word      = bit_cnt_d[5] ? active_r_d : active_l_d;
         bit_idx   = 5'd16 - slot;
         if (slot >= 5'd1 && slot <= 5'd16) begin
            dac_d = word[bit_idx[3:0]];
         end else begin
            dac_d = 1'b0;
         end
      end
   end

   // State registers; reset discards any partially shifted word
   always_ff @(posedge CLOCK_50 or posedge AUD_DACLRCK) begin
      if (AUD_DACLRCK) begin
         div_cnt_q     <= '0;
         bclk_q        <= 1'b0;
         bit_cnt_q     <= '0;
         lrck_q        <= 1'b0;
         dac_q         <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         active_l_q    <= '0;
         active_r_q    <= '0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         bclk_q        <= bclk_d;
         bit_cnt_q     <= bit_cnt_d;
         lrck_q        <= lrck_d;
         dac_q         <= dac_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         hold_full_q   <= hold_full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         active_l_q    <= active_l_d;
         active_r_q    <= active_r_d;
      end
   end

   // Output mapping
   always_comb begin
      sample_ready = ~hold_full_q;
      AUD_BCLK_O   = bclk_q;
      LRCK_OUT     = lrck_q;
      AUD_DACDAT   = dac_q;
      frame_start  = frame_start_q;
      underrun     = underrun_q;
   end

endmodule
